// File: rtl/msk_bit_sync_if.sv
// Sample/bit/word bus between the baseband filter, the bit synchroniser and its consumer.
interface msk_bit_sync_if #(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned WORD_W   = 30
);
    logic                       sample_valid;
    logic signed [SAMPLE_W-1:0] sample_in;
    logic [15:0]                samples_per_bit;
    logic                       bit_out;
    logic                       bit_valid;
    logic [WORD_W-1:0]          word_out;
    logic                       word_valid;
    logic                       locked;
    logic [1:0]                 miss_count;

    // Sample source side.
    modport master (
        output sample_valid, sample_in, samples_per_bit,
        input  bit_out, bit_valid, word_out, word_valid, locked, miss_count
    );

    // Bit synchroniser side.
    modport slave (
        input  sample_valid, sample_in, samples_per_bit,
        output bit_out, bit_valid, word_out, word_valid, locked, miss_count
    );
endinterface

// File: rtl/msk_bit_sync.sv
// MSK receive bit synchroniser: integrate-and-dump slicer with zero-crossing timing
// recovery, followed by a preamble framer that reassembles WORD_W-bit DGPS words.
module msk_bit_sync #(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned ACC_W    = 32,
    parameter int unsigned WORD_W   = 30,
    parameter logic [7:0]  PREAMBLE = 8'b01100110,
    parameter int unsigned MAX_MISS = 3
) (
    input logic           clk,
    input logic           reset,
    msk_bit_sync_if.slave bus
);
    localparam int unsigned BCW = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {StHunt, StFrame, StTrack} state_e;

    // Bit timing / integrator state
    logic [15:0]             period_q, period_d;
    logic [15:0]             cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    prev_sign_q, prev_sign_d;

    // Framer state
    state_e                  state_q, state_d;
    logic [WORD_W-1:0]       sr_q, sr_d;
    logic [BCW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [1:0]              miss_q, miss_d;

    // Registered outputs
    logic                    bit_out_q, bit_out_d;
    logic                    bit_valid_q, bit_valid_d;
    logic [WORD_W-1:0]       word_out_q, word_out_d;
    logic                    word_valid_q, word_valid_d;

    // Combinational helpers
    logic signed [ACC_W-1:0] sample_ext;
    logic signed [ACC_W-1:0] acc_sum;
    logic                    sample_sign;
    logic                    crossing;
    logic [15:0]             half;
    logic [15:0]             last_cnt;
    logic                    dump;
    logic                    bit_dec;
    logic [WORD_W-1:0]       sr_new;
    logic [BCW-1:0]          bit_cnt_inc;
    logic [1:0]              miss_inc;
    logic                    word_done;

    assign sample_ext  = {{(ACC_W - SAMPLE_W){bus.sample_in[SAMPLE_W-1]}}, bus.sample_in};
    assign acc_sum     = acc_q + sample_ext;
    assign sample_sign = bus.sample_in[SAMPLE_W-1];
    assign crossing    = sample_sign != prev_sign_q;
    assign half        = period_q >> 1;
    assign last_cnt    = period_q - 16'd1;
    assign sr_new      = {sr_q[WORD_W-2:0], bit_dec};
    assign bit_cnt_inc = bit_cnt_q + BCW'(1);
    assign miss_inc    = miss_q + 2'd1;
    // A word completes on the bit that brings the framing count up to WORD_W.
    assign word_done   = dump && (state_q != StHunt) && (bit_cnt_inc == BCW'(WORD_W));

    // Timing recovery and integrate-and-dump; only valid samples move anything.
    always_comb begin
        period_d    = period_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        prev_sign_d = prev_sign_q;
        dump        = 1'b0;
        bit_dec     = 1'b0;
        if (bus.sample_valid) begin
            prev_sign_d = sample_sign;
            if (cnt_q == last_cnt) begin
                // Exact zero slices to 0.
                dump     = 1'b1;
                bit_dec  = !acc_sum[ACC_W-1] && (acc_sum != '0);
                acc_d    = '0;
                cnt_d    = '0;
                period_d = bus.samples_per_bit;
            end else begin
                acc_d = acc_sum;
                if (crossing && (cnt_q != 16'd0) && (cnt_q < half)) begin
                    cnt_d = cnt_q;                  // early: stretch this bit by one sample
                end else if (crossing && (cnt_q >= half) && (cnt_q < period_q - 16'd2)) begin
                    cnt_d = cnt_q + 16'd2;          // late: never jumps past the dump count
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
        end
    end

    // Timing/integrator registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            period_q    <= bus.samples_per_bit;
            cnt_q       <= '0;
            acc_q       <= '0;
            prev_sign_q <= 1'b0;
        end else begin
            period_q    <= period_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            prev_sign_q <= prev_sign_d;
        end
    end

    // Framer next state: preamble hunt, first word, then word-by-word tracking.
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        miss_d    = miss_q;
        if (dump) begin
            sr_d = sr_new;
            unique case (state_q)
                StHunt: begin
                    if (sr_new[7:0] == PREAMBLE) begin
                        state_d   = StFrame;
                        bit_cnt_d = BCW'(8);
                    end
                end
                StFrame: begin
                    if (word_done) begin
                        state_d   = StTrack;
                        bit_cnt_d = '0;
                        miss_d    = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_inc;
                    end
                end
                StTrack: begin
                    if (word_done) begin
                        bit_cnt_d = '0;
                        if (sr_new[WORD_W-1 -: 8] != PREAMBLE) begin
                            miss_d = miss_inc;
                            // The word that exhausts the miss budget is still emitted.
                            if (miss_inc == 2'(MAX_MISS)) begin
                                state_d = StHunt;
                            end
                        end else begin
                            miss_d = '0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_inc;
                    end
                end
                default: state_d = StHunt;
            endcase
        end
    end

    // Framer outputs: strobes pulse for one edge, data holds between strobes.
    always_comb begin
        bit_out_d    = bit_out_q;
        bit_valid_d  = 1'b0;
        word_out_d   = word_out_q;
        word_valid_d = 1'b0;
        if (dump) begin
            bit_out_d   = bit_dec;
            bit_valid_d = 1'b1;
        end
        if (word_done) begin
            word_out_d   = sr_new;
            word_valid_d = 1'b1;
        end
    end

    // Framer and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StHunt;
            sr_q         <= '0;
            bit_cnt_q    <= '0;
            miss_q       <= '0;
            bit_out_q    <= 1'b0;
            bit_valid_q  <= 1'b0;
            word_out_q   <= '0;
            word_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            bit_cnt_q    <= bit_cnt_d;
            miss_q       <= miss_d;
            bit_out_q    <= bit_out_d;
            bit_valid_q  <= bit_valid_d;
            word_out_q   <= word_out_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign bus.bit_out    = bit_out_q;
    assign bus.bit_valid  = bit_valid_q;
    assign bus.word_out   = word_out_q;
    assign bus.word_valid = word_valid_q;
    assign bus.locked     = (state_q == StTrack);
    assign bus.miss_count = miss_q;
endmodule

// File: tb/tb_msk_bit_sync.sv
// Directed bench for msk_bit_sync: slicing, timing recovery, framing, miss handling, reset.
module tb_msk_bit_sync;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    msk_bit_sync_if bus ();

    msk_bit_sync dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    localparam logic [29:0] FRAME_WORD = 30'h19955555;
    localparam logic [29:0] MISS_WORD  = 30'h00155555;

    int checks = 0;
    int errors = 0;

    // Recorder state, filled by step()
    int          cyc     = 0;
    int          n_samp  = 0;
    int          acc_bad = 0;
    int          wv_bad  = 0;
    logic        bit_q[$];
    int          bit_samp_q[$];
    int          bit_cyc_q[$];
    logic [29:0] word_q[$];
    logic [1:0]  miss_q[$];
    logic        lock_q[$];

    // One clock with the given inputs; outputs observed 1 ns after the edge.
    task automatic step(input logic v, input logic signed [15:0] x);
        bus.sample_valid = v;
        bus.sample_in    = x;
        @(posedge clk);
        #1;
        cyc++;
        if (v) n_samp++;
        if (bus.bit_valid) begin
            bit_q.push_back(bus.bit_out);
            bit_samp_q.push_back(n_samp);
            bit_cyc_q.push_back(cyc);
            if (dut.acc_q != 0) acc_bad++;
        end
        if (bus.word_valid) begin
            word_q.push_back(bus.word_out);
            miss_q.push_back(bus.miss_count);
            lock_q.push_back(bus.locked);
            if (!bus.bit_valid) wv_bad++;
        end
        bus.sample_valid = 1'b0;
    endtask

    task automatic clear_rec();
        bit_q.delete();
        bit_samp_q.delete();
        bit_cyc_q.delete();
        word_q.delete();
        miss_q.delete();
        lock_q.delete();
        n_samp = 0;
    endtask

    task automatic do_reset(input logic [15:0] p);
        bus.samples_per_bit = p;
        reset = 1'b1;
        step(1'b0, 16'sd0);
        reset = 1'b0;
        clear_rec();
    endtask

    task automatic send_bit(input logic b);
        repeat (8) step(1'b1, b ? 16'sd1000 : -16'sd1000);
    endtask

    task automatic send_bits(input logic [29:0] w, input int first, input int last);
        for (int i = first; i <= last; i++) send_bit(w[29-i]);
    endtask

    task automatic test_reset();
        bus.samples_per_bit = 16'd8;
        reset = 1'b1;
        step(1'b1, 16'sd1000);
        step(1'b0, 16'sd0);
        reset = 1'b0;
        checks++; if (bus.bit_out !== 1'b0) begin errors++; $display("FAIL reset_bit_out: got %b want 0", bus.bit_out); end
        checks++; if (bus.bit_valid !== 1'b0) begin errors++; $display("FAIL reset_bit_valid: got %b want 0", bus.bit_valid); end
        checks++; if (bus.word_out !== 30'h0) begin errors++; $display("FAIL reset_word_out: got %h want 0", bus.word_out); end
        checks++; if (bus.word_valid !== 1'b0) begin errors++; $display("FAIL reset_word_valid: got %b want 0", bus.word_valid); end
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", bus.locked); end
        checks++; if (bus.miss_count !== 2'd0) begin errors++; $display("FAIL reset_miss: got %0d want 0", bus.miss_count); end
        clear_rec();
    endtask

    task automatic test_constant();
        do_reset(16'd8);
        repeat (32) begin
            step(1'b1, 16'sd1000);
            repeat (3) step(1'b0, 16'sd0);
        end
        checks++; if (bit_q.size() !== 4) begin errors++; $display("FAIL const_nbits: got %0d want 4", bit_q.size()); end
        for (int i = 0; i < bit_q.size(); i++) begin
            checks++; if (bit_q[i] !== 1'b1) begin errors++; $display("FAIL const_bit[%0d]: got %b want 1", i, bit_q[i]); end
        end
        for (int i = 1; i < bit_cyc_q.size(); i++) begin
            checks++;
            if (bit_cyc_q[i] - bit_cyc_q[i-1] !== 32) begin
                errors++; $display("FAIL const_spacing[%0d]: got %0d want 32", i, bit_cyc_q[i] - bit_cyc_q[i-1]);
            end
        end
        checks++; if (acc_bad !== 0) begin errors++; $display("FAIL const_acc_clear: got %0d nonzero dumps want 0", acc_bad); end
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL const_locked: got %b want 0", bus.locked); end
        checks++; if (word_q.size() !== 0) begin errors++; $display("FAIL const_words: got %0d want 0", word_q.size()); end
    endtask

    task automatic test_frame();
        logic [29:0] w;
        w = FRAME_WORD;
        do_reset(16'd8);
        send_bits(w, 0, 29);
        checks++; if (bit_q.size() !== 30) begin errors++; $display("FAIL frame_nbits: got %0d want 30", bit_q.size()); end
        for (int i = 0; i < bit_q.size() && i < 30; i++) begin
            checks++; if (bit_q[i] !== w[29-i]) begin errors++; $display("FAIL frame_bit[%0d]: got %b want %b", i, bit_q[i], w[29-i]); end
        end
        checks++; if (word_q.size() !== 1) begin errors++; $display("FAIL frame_nwords: got %0d want 1", word_q.size()); end
        if (word_q.size() > 0) begin
            checks++; if (word_q[0] !== 30'h19955555) begin errors++; $display("FAIL frame_word: got %h want 19955555", word_q[0]); end
            checks++; if (lock_q[0] !== 1'b1) begin errors++; $display("FAIL frame_lock_at_word: got %b want 1", lock_q[0]); end
        end
        checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL frame_locked: got %b want 1", bus.locked); end
        checks++; if (bus.miss_count !== 2'd0) begin errors++; $display("FAIL frame_miss: got %0d want 0", bus.miss_count); end
    endtask

    // Source 3 samples late: holds at cnt 3, 2, 1 pull the boundaries back to cnt 0.
    task automatic test_phase();
        logic [29:0] w;
        int          exp_samp;
        w = FRAME_WORD;
        do_reset(16'd8);
        repeat (3) step(1'b1, 16'sd1000);
        send_bits(w, 0, 29);
        checks++; if (bit_q.size() !== 30) begin errors++; $display("FAIL phase_nbits: got %0d want 30", bit_q.size()); end
        for (int i = 0; i < bit_q.size() && i < 30; i++) begin
            case (i)
                0: exp_samp = 9;
                1: exp_samp = 18;
                2: exp_samp = 26;
                default: exp_samp = 35 + 8 * (i - 3);
            endcase
            checks++;
            if (bit_samp_q[i] !== exp_samp) begin
                errors++; $display("FAIL phase_dump_at[%0d]: got sample %0d want %0d", i, bit_samp_q[i], exp_samp);
            end
            checks++; if (bit_q[i] !== w[29-i]) begin errors++; $display("FAIL phase_bit[%0d]: got %b want %b", i, bit_q[i], w[29-i]); end
        end
        checks++; if (word_q.size() !== 1) begin errors++; $display("FAIL phase_nwords: got %0d want 1", word_q.size()); end
        if (word_q.size() > 0) begin
            checks++; if (word_q[0] !== 30'h19955555) begin errors++; $display("FAIL phase_word: got %h want 19955555", word_q[0]); end
        end
        checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL phase_locked: got %b want 1", bus.locked); end
    endtask

    // Crossing at cnt == half advances by 2, so the first bit dumps on sample 7 with acc = +1000.
    task automatic test_advance();
        do_reset(16'd8);
        repeat (4) step(1'b1, 16'sd1000);
        repeat (3) step(1'b1, -16'sd1000);
        checks++; if (bit_q.size() !== 1) begin errors++; $display("FAIL adv_nbits: got %0d want 1", bit_q.size()); end
        if (bit_q.size() > 0) begin
            checks++; if (bit_samp_q[0] !== 7) begin errors++; $display("FAIL adv_dump_at: got %0d want 7", bit_samp_q[0]); end
            checks++; if (bit_q[0] !== 1'b1) begin errors++; $display("FAIL adv_bit: got %b want 1", bit_q[0]); end
        end
    endtask

    task automatic test_miss();
        logic [29:0] w;
        do_reset(16'd8);
        w = FRAME_WORD;
        send_bits(w, 0, 29);
        w = MISS_WORD;
        for (int k = 0; k < 3; k++) send_bits(w, 0, 29);
        checks++; if (word_q.size() !== 4) begin errors++; $display("FAIL miss_nwords: got %0d want 4", word_q.size()); end
        for (int k = 1; k < word_q.size() && k < 4; k++) begin
            checks++; if (word_q[k] !== 30'h00155555) begin errors++; $display("FAIL miss_word[%0d]: got %h want 00155555", k, word_q[k]); end
            checks++; if (miss_q[k] !== 2'(k)) begin errors++; $display("FAIL miss_count[%0d]: got %0d want %0d", k, miss_q[k], k); end
            checks++;
            if (lock_q[k] !== (k < 3)) begin
                errors++; $display("FAIL miss_lock[%0d]: got %b want %b", k, lock_q[k], (k < 3));
            end
        end
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL miss_unlocked: got %b want 0", bus.locked); end
    endtask

    task automatic test_zero_reset();
        logic [29:0] w;
        do_reset(16'd8);
        repeat (8) step(1'b1, 16'sd1000);
        repeat (8) step(1'b1, 16'sd0);
        checks++; if (bit_q.size() !== 2) begin errors++; $display("FAIL zero_nbits: got %0d want 2", bit_q.size()); end
        if (bit_q.size() == 2) begin
            checks++; if (bit_q[0] !== 1'b1) begin errors++; $display("FAIL zero_first_bit: got %b want 1", bit_q[0]); end
            checks++; if (bit_q[1] !== 1'b0) begin errors++; $display("FAIL zero_bit: got %b want 0", bit_q[1]); end
        end

        // Lock, then reset five samples into bit 10 of the next word.
        w = FRAME_WORD;
        do_reset(16'd8);
        send_bits(w, 0, 29);
        send_bits(w, 0, 9);
        repeat (5) step(1'b1, -16'sd1000);
        checks++; if (bus.bit_out !== 1'b1) begin errors++; $display("FAIL mid_pre_bit_out: got %b want 1", bus.bit_out); end
        checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL mid_pre_locked: got %b want 1", bus.locked); end
        reset = 1'b1;
        step(1'b1, -16'sd1000);
        reset = 1'b0;
        checks++; if (bus.bit_out !== 1'b0) begin errors++; $display("FAIL mid_bit_out: got %b want 0", bus.bit_out); end
        checks++; if (bus.bit_valid !== 1'b0) begin errors++; $display("FAIL mid_bit_valid: got %b want 0", bus.bit_valid); end
        checks++; if (bus.word_out !== 30'h0) begin errors++; $display("FAIL mid_word_out: got %h want 0", bus.word_out); end
        checks++; if (bus.word_valid !== 1'b0) begin errors++; $display("FAIL mid_word_valid: got %b want 0", bus.word_valid); end
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL mid_locked: got %b want 0", bus.locked); end
        checks++; if (bus.miss_count !== 2'd0) begin errors++; $display("FAIL mid_miss: got %0d want 0", bus.miss_count); end
        clear_rec();
        repeat (2) step(1'b1, -16'sd1000);
        send_bits(w, 11, 29);
        checks++; if (word_q.size() !== 0) begin errors++; $display("FAIL mid_no_word: got %0d words want 0", word_q.size()); end
    endtask

    task automatic test_period_change();
        do_reset(16'd8);
        repeat (3) step(1'b1, 16'sd1000);
        bus.samples_per_bit = 16'd16;
        repeat (37) step(1'b1, 16'sd1000);
        checks++; if (bit_samp_q.size() !== 3) begin errors++; $display("FAIL per_nbits: got %0d want 3", bit_samp_q.size()); end
        if (bit_samp_q.size() == 3) begin
            checks++; if (bit_samp_q[0] !== 8) begin errors++; $display("FAIL per_dump0: got %0d want 8", bit_samp_q[0]); end
            checks++; if (bit_samp_q[1] !== 24) begin errors++; $display("FAIL per_dump1: got %0d want 24", bit_samp_q[1]); end
            checks++; if (bit_samp_q[2] !== 40) begin errors++; $display("FAIL per_dump2: got %0d want 40", bit_samp_q[2]); end
        end
    endtask

    task automatic test_invariants();
        checks++; if (wv_bad !== 0) begin errors++; $display("FAIL word_without_bit: got %0d want 0", wv_bad); end
        checks++; if (acc_bad !== 0) begin errors++; $display("FAIL acc_not_cleared: got %0d want 0", acc_bad); end
    endtask

    initial begin
        reset               = 1'b1;
        bus.sample_valid    = 1'b0;
        bus.sample_in       = '0;
        bus.samples_per_bit = 16'd8;
        test_reset();
        test_constant();
        test_frame();
        test_phase();
        test_advance();
        test_miss();
        test_zero_reset();
        test_period_change();
        test_invariants();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
